// File: rtl/rtclock_adj.sv
// Disciplined time-of-day counter {sec, nsec, frac} with a trimmable ns.frac rate,
// atomic time load, signed phase step and a pulse-per-second strobe.
module rtclock_adj #(
  parameter int C_SEC_WIDTH  = 48,
  parameter int C_NS_INC     = 8,
  parameter int C_FRAC_BITS  = 16,
  parameter int C_PPS_CYCLES = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     set_wr,
  input  logic [C_SEC_WIDTH-1:0]   set_sec,
  input  logic [29:0]              set_nsec,
  input  logic                     adj_wr,
  input  logic [31:0]              adj_nsec,
  input  logic                     incr_wr,
  input  logic [8+C_FRAC_BITS-1:0] incr_val,
  output logic [C_SEC_WIDTH-1:0]   sec,
  output logic [29:0]              nsec,
  output logic [C_FRAC_BITS-1:0]   nsec_frac,
  output logic                     pps,
  output logic                     set_err
);

  localparam int IW = 8 + C_FRAC_BITS;
  localparam int CW = $clog2(C_PPS_CYCLES + 1);
  localparam logic signed [33:0] NS_PER_SEC = 34'sd1000000000;
  localparam logic [IW-1:0]      INC_RST    = IW'(C_NS_INC) << C_FRAC_BITS;
  localparam logic [29:0]        NS_LIMIT   = 30'd1000000000;

  // Folds a signed ns sum back into one second; {dir, ns} with dir 01=carry, 10=borrow.
  // A final clamp keeps nsec legal even for out-of-range phase steps.
  function automatic logic [31:0] norm_ns(input logic signed [33:0] s);
    logic signed [33:0] t;
    logic [1:0]         dir;
    t   = s;
    dir = 2'b00;
    if (s >= NS_PER_SEC) begin
      t   = s - NS_PER_SEC;
      dir = 2'b01;
    end else if (s < 34'sd0) begin
      t   = s + NS_PER_SEC;
      dir = 2'b10;
    end
    if (t >= NS_PER_SEC)    t = NS_PER_SEC - 34'sd1;
    else if (t < 34'sd0)    t = 34'sd0;
    return {dir, t[29:0]};
  endfunction

  logic [C_SEC_WIDTH-1:0] sec_q, sec_d;
  logic [29:0]            nsec_q, nsec_d;
  logic [C_FRAC_BITS-1:0] frac_q, frac_d;
  logic [IW-1:0]          inc_q, inc_d;
  logic [CW-1:0]          pps_cnt_q, pps_cnt_d;
  logic                   pps_q, pps_d;
  logic                   set_err_q, set_err_d;

  logic [C_FRAC_BITS:0]   frac_sum;
  logic signed [33:0]     ns_pre, adj_eff, ns_sum;
  logic [31:0]            norm;
  logic                   set_ok, carry;

  always_comb begin
    set_ok   = set_wr && (set_nsec < NS_LIMIT);
    frac_sum = {1'b0, frac_q} + {1'b0, inc_q[C_FRAC_BITS-1:0]};
    ns_pre   = 34'(nsec_q) + 34'(inc_q[IW-1:C_FRAC_BITS]) + 34'(frac_sum[C_FRAC_BITS]);
    adj_eff  = adj_wr ? {{2{adj_nsec[31]}}, adj_nsec} : 34'sd0;
    ns_sum   = ns_pre + adj_eff;
    norm     = norm_ns(ns_sum);

    sec_d  = sec_q;
    nsec_d = norm[29:0];
    frac_d = frac_sum[C_FRAC_BITS-1:0];
    carry  = 1'b0;
    if (set_ok) begin
      sec_d  = set_sec;
      nsec_d = set_nsec;
      frac_d = '0;
    end else if (norm[31:30] == 2'b01) begin
      sec_d  = sec_q + C_SEC_WIDTH'(1);
      carry  = 1'b1;
    end else if (norm[31:30] == 2'b10) begin
      sec_d  = sec_q - C_SEC_WIDTH'(1);
    end

    // A forward carry (re)starts the pulse; a load leaves a running pulse alone.
    if (carry)                pps_cnt_d = CW'(C_PPS_CYCLES);
    else if (pps_cnt_q != '0) pps_cnt_d = pps_cnt_q - CW'(1);
    else                      pps_cnt_d = pps_cnt_q;
    pps_d     = (pps_cnt_d != '0);
    set_err_d = set_wr && !set_ok;
    inc_d     = incr_wr ? incr_val : inc_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sec_q     <= '0;
      nsec_q    <= '0;
      frac_q    <= '0;
      inc_q     <= INC_RST;
      pps_cnt_q <= '0;
      pps_q     <= 1'b0;
      set_err_q <= 1'b0;
    end else begin
      sec_q     <= sec_d;
      nsec_q    <= nsec_d;
      frac_q    <= frac_d;
      inc_q     <= inc_d;
      pps_cnt_q <= pps_cnt_d;
      pps_q     <= pps_d;
      set_err_q <= set_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) assert (nsec_q < NS_LIMIT);
  end

  assign sec       = sec_q;
  assign nsec      = nsec_q;
  assign nsec_frac = frac_q;
  assign pps       = pps_q;
  assign set_err   = set_err_q;

endmodule

// File: tb/tb_rtclock_adj.sv
// Bench for rtclock_adj: a time-value reference model checked every cycle,
// directed scenarios with literal expectations, then randomized strobes.
module tb_rtclock_adj;

  localparam int  F  = 16;
  localparam int  P  = 4;
  localparam longint NS1 = 64'd1000000000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        set_wr = 1'b0;
  logic [47:0] set_sec = '0;
  logic [29:0] set_nsec = '0;
  logic        adj_wr = 1'b0;
  logic [31:0] adj_nsec = '0;
  logic        incr_wr = 1'b0;
  logic [23:0] incr_val = '0;
  logic [47:0] sec;
  logic [29:0] nsec;
  logic [15:0] nsec_frac;
  logic        pps;
  logic        set_err;

  rtclock_adj dut (
    .clk(clk), .reset(reset), .set_wr(set_wr), .set_sec(set_sec), .set_nsec(set_nsec),
    .adj_wr(adj_wr), .adj_nsec(adj_nsec), .incr_wr(incr_wr), .incr_val(incr_val),
    .sec(sec), .nsec(nsec), .nsec_frac(nsec_frac), .pps(pps), .set_err(set_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: time held as seconds plus a single ns*2^F quantity
  logic [47:0] m_sec;
  longint      m_t;
  longint      m_inc;
  int          m_pps_rem;
  bit          m_err;
  bit          m_valid = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    longint t2, ns, a;
    bit ok;
    bit carry;
    if (reset) begin
      m_sec = '0; m_t = 0; m_inc = 64'(8) << F; m_pps_rem = 0; m_err = 0; m_valid = 1'b1;
      return;
    end
    ok    = set_wr && (longint'(set_nsec) < NS1);
    carry = 1'b0;
    if (ok) begin
      m_sec = set_sec;
      m_t   = longint'(set_nsec) << F;
    end else begin
      t2 = m_t + m_inc;
      ns = t2 >> F;
      if (adj_wr) begin
        a  = longint'($signed(adj_nsec));
        ns = ns + a;
      end
      if (ns >= NS1) begin
        ns = ns - NS1; m_sec = m_sec + 48'd1; carry = 1'b1;
      end else if (ns < 0) begin
        ns = ns + NS1; m_sec = m_sec - 48'd1;
      end
      m_t = (ns << F) + (t2 % (64'(1) << F));
    end
    if (carry)              m_pps_rem = P;
    else if (m_pps_rem > 0) m_pps_rem = m_pps_rem - 1;
    m_err = set_wr && !ok;
    if (incr_wr) m_inc = longint'(incr_val);
  endtask

  task automatic check_all();
    if (!m_valid) return;
    chk("sec",   64'(sec),       64'(m_sec));
    chk("nsec",  64'(nsec),      64'(m_t >> F));
    chk("frac",  64'(nsec_frac), 64'(m_t % (64'(1) << F)));
    chk("pps",   64'(pps),       64'(m_pps_rem > 0));
    chk("serr",  64'(set_err),   64'(m_err));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic do_set(input logic [47:0] s, input logic [29:0] n);
    set_wr = 1'b1; set_sec = s; set_nsec = n;
    cyc();
    set_wr = 1'b0;
  endtask

  task automatic do_adj(input int a);
    adj_wr = 1'b1; adj_nsec = 32'(a);
    cyc();
    adj_wr = 1'b0;
  endtask

  initial begin
    int r;
    // Reset and free run at the default rate
    cyc(); cyc();
    chk("rst_sec", 64'(sec), 64'd0);
    chk("rst_nsec", 64'(nsec), 64'd0);
    chk("rst_pps", 64'(pps), 64'd0);
    reset = 1'b0;
    cyc(); chk("run_ns8", 64'(nsec), 64'd8);
    cyc(); chk("run_ns16", 64'(nsec), 64'd16);
    cyc(); chk("run_ns24", 64'(nsec), 64'd24);
    chk("run_frac", 64'(nsec_frac), 64'd0);
    reset = 1'b1;
    cyc(); chk("rst2_nsec", 64'(nsec), 64'd0);
    reset = 1'b0;

    // Load near a second boundary; carry and pps pulse length
    do_set(48'd5, 30'd999999992);
    chk("set_sec", 64'(sec), 64'd5);
    chk("set_ns", 64'(nsec), 64'd999999992);
    cyc();
    chk("carry_sec", 64'(sec), 64'd6);
    chk("carry_ns", 64'(nsec), 64'd0);
    chk("pps_c1", 64'(pps), 64'd1);
    cyc(); chk("pps_c2", 64'(pps), 64'd1);
    cyc(); chk("pps_c3", 64'(pps), 64'd1);
    cyc(); chk("pps_c4", 64'(pps), 64'd1);
    cyc(); chk("pps_end", 64'(pps), 64'd0);

    // Fractional rate 8.5 ns from the first edge after reset
    reset = 1'b1; cyc(); reset = 1'b0;
    incr_wr = 1'b1; incr_val = 24'h088000;
    cyc(); incr_wr = 1'b0;
    chk("inc_ns0", 64'(nsec), 64'd8);  chk("inc_fr0", 64'(nsec_frac), 64'h0);
    cyc();
    chk("inc_ns1", 64'(nsec), 64'd16); chk("inc_fr1", 64'(nsec_frac), 64'h8000);
    cyc();
    chk("inc_ns2", 64'(nsec), 64'd25); chk("inc_fr2", 64'(nsec_frac), 64'h0);
    cyc();
    chk("inc_ns3", 64'(nsec), 64'd33); chk("inc_fr3", 64'(nsec_frac), 64'h8000);
    reset = 1'b1; cyc(); reset = 1'b0;

    // Negative step across second boundary, then positive step with carry
    do_set(48'd3, 30'd40);
    do_adj(-100);
    chk("borrow_sec", 64'(sec), 64'd2);
    chk("borrow_ns", 64'(nsec), 64'd999999948);
    chk("borrow_pps", 64'(pps), 64'd0);
    do_set(48'd2, 30'd999999000);
    do_adj(1000);
    chk("adjc_sec", 64'(sec), 64'd3);
    chk("adjc_ns", 64'(nsec), 64'd8);
    chk("adjc_pps", 64'(pps), 64'd1);

    // Rejected load, then load colliding with a step
    do_set(48'd9, 30'd1000000000);
    chk("err_pulse", 64'(set_err), 64'd1);
    chk("err_ns", 64'(nsec), 64'd16);
    chk("err_sec", 64'(sec), 64'd3);
    set_wr = 1'b1; set_sec = 48'd7; set_nsec = 30'd123; adj_wr = 1'b1; adj_nsec = 32'd500;
    cyc();
    set_wr = 1'b0; adj_wr = 1'b0;
    chk("coll_sec", 64'(sec), 64'd7);
    chk("coll_ns", 64'(nsec), 64'd123);
    chk("coll_err", 64'(set_err), 64'd0);

    // Seconds wrap both ways
    do_set(48'hFFFF_FFFF_FFFF, 30'd999999992);
    cyc();
    chk("wrap_sec", 64'(sec), 64'd0);
    chk("wrap_ns", 64'(nsec), 64'd0);
    chk("wrap_pps", 64'(pps), 64'd1);
    do_set(48'd0, 30'd0);
    do_adj(-1000);
    chk("uwrap_sec", 64'(sec), 64'hFFFF_FFFF_FFFF);
    chk("uwrap_ns", 64'(nsec), 64'd999999008);

    // Randomized strobes
    for (int i = 0; i < 3000; i++) begin
      r        = int'($urandom_range(0, 199));
      reset    = (r == 0);
      set_wr   = ($urandom_range(0, 15) == 0);
      set_sec  = 48'({$urandom(), $urandom()});
      case ($urandom_range(0, 3))
        0:       set_nsec = 30'($urandom_range(999999990, 1073741823));
        1:       set_nsec = 30'($urandom_range(999999000, 999999999));
        default: set_nsec = 30'($urandom_range(0, 999999999));
      endcase
      adj_wr   = ($urandom_range(0, 9) == 0);
      adj_nsec = 32'(int'($urandom_range(0, 1999997998)) - 999998999);
      incr_wr  = ($urandom_range(0, 30) == 0);
      incr_val = ($urandom_range(0, 7) == 0) ? 24'h0 : 24'($urandom());
      cyc();
    end
    reset = 1'b0; set_wr = 1'b0; adj_wr = 1'b0; incr_wr = 1'b0;
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rtclock_adj.md
Name: rtclock_adj

Overview:
Parametrised, disciplined real-time clock that keeps {sec, nsec, frac} time of day in the core clock domain. It supersedes the fixed-step counter with three additions: a fractional-ns increment rate that control software can trim for drift, atomic time load, and a signed phase step. It also generates a pulse-per-second strobe. It feeds timestamping and the packet generator/checker cores.

Parameters:
C_SEC_WIDTH, 48, width of seconds counter; wraps modulo 2^C_SEC_WIDTH
C_NS_INC, 8, integer ns per clk at reset (default rate)
C_FRAC_BITS, 16, fractional-ns bits in accumulator and increment
C_PPS_CYCLES, 4, pps pulse length in clk cycles (>=1)

Ports:
clk  in  1  core clock
reset  in  1  synchronous, active-high reset
set_wr  in  1  one-cycle strobe: load set_sec/set_nsec
set_sec  in  C_SEC_WIDTH  seconds to load
set_nsec  in  30  ns to load; must be < 1e9
adj_wr  in  1  one-cycle strobe: apply phase step adj_nsec
adj_nsec  in  32  signed two's-complement ns step; |adj_nsec| < 999_999_000
incr_wr  in  1  one-cycle strobe: load new increment
incr_val  in  8+C_FRAC_BITS  unsigned increment, ns.frac
sec  out  C_SEC_WIDTH  seconds
nsec  out  30  nanoseconds, always in [0, 999_999_999]
nsec_frac  out  C_FRAC_BITS  fractional ns
pps  out  1  high C_PPS_CYCLES cycles from each forward second carry
set_err  out  1  one-cycle pulse: set_wr rejected (set_nsec >= 1e9)

Behaviour:
- Reset (reset=1 at posedge): sec=0, nsec=0, nsec_frac=0, pps=0, set_err=0, inc register=C_NS_INC<<C_FRAC_BITS, pps counter=0. Reset overrides all strobes in the same cycle.
- All outputs are registered. Any strobe sampled at edge N takes effect in the outputs at edge N+1.
- Normal tick, every cycle: {nsec,frac} += inc.
  - If the result >= 1e9<<C_FRAC_BITS: subtract 1e9 ns, sec+1 (carry).
  - At most one carry per cycle, guaranteed by inc < 256 ns.
- incr_wr: inc <= incr_val at edge N. The tick at edge N still uses the old inc; the new inc is used from N+1. incr_val=0 freezes time; this is legal.
- set_wr with set_nsec < 1e9: sec<=set_sec, nsec<=set_nsec, frac<=0. No tick is added that cycle. Any concurrent adj_wr is discarded. pps is not triggered, and an in-progress pps pulse completes normally.
- set_wr with set_nsec >= 1e9: load is ignored, the normal tick/adj proceeds, and set_err pulses 1 cycle.
- adj_wr (no valid set): the ns sum is computed signed, s = nsec + inc_ns_part (+frac carry) + adj_nsec, using >=33-bit signed arithmetic.
  - s >= 1e9: nsec=s-1e9, sec+1 (counts as a carry).
  - s < 0: nsec=s+1e9, sec-1 (borrow, no pps).
  - Otherwise nsec=s.
  - frac is unaffected by adj.
- Priority: reset > valid set > adj+tick > tick. incr_wr is independent and may coincide with any of these.
- sec wraps silently: all-ones+1 -> 0, and 0-1 -> all-ones.
- pps: on every forward carry (tick or adj), pps=1 for C_PPS_CYCLES cycles starting at the same edge where sec increments. A carry during an active pulse restarts the count.
- Out-of-range adj_nsec is the caller's responsibility. Behaviour is undefined, but nsec must never exceed 999_999_999; the implementation asserts this in simulation.

Test Plan:
- Reset then 3 free cycles, defaults -> sec=0, nsec=8,16,24, frac=0, pps=0; reset asserted mid-run at nsec=24 -> next edge all outputs 0.
- set_wr sec=5 nsec=999_999_992 -> next edge sec=5 nsec=999_999_992; following edge sec=6 nsec=0, pps=1 for exactly 4 cycles, then 0.
- incr_wr incr_val=0x088000 (8.5 ns) at time 0 -> nsec/frac sequence 8/0 (old rate on write edge), 16/0x8000, 25/0, 33/0x8000.
- At sec=3 nsec=40, adj_wr adj_nsec=-100 -> next edge sec=2 nsec=999_999_948, pps=0; adj_wr +1_000 at nsec=999_999_000 -> sec+1, nsec=8, pps pulse.
- set_wr nsec=1_000_000_000 -> set_err=1 for one cycle, time continues +8; same-cycle set_wr (valid) and adj_wr -> set value loaded exactly, adj dropped.
- sec=2^48-1, nsec=999_999_992 -> next edge sec=0 nsec=0 pps=1; sec=0 with adj -1_000 at nsec=0 -> sec=2^48-1, nsec=999_999_008.
